oam_dma: RTL and testbench

// - Sprite DMA engine on the CPU bus, directly downstream of the 6502 core. Sits between the core's
//   o_address/o_rw/o_data and the system bus.
// - A CPU write to $4014 stalls the core via o_cpu_rdy. The engine then copies 256 bytes from page
//   $XX00 to the PPU OAM data port $2004.
// - When idle, it passes the core's bus signals through unchanged.

---
 rtl/oam_dma_pkg.sv | 35 +++
 rtl/oam_dma.sv | 176 +++++++++++++++++
 tb/tb_oam_dma.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
//   Shared CPU-bus definitions for the sprite DMA engine: bus direction
//   encodings, the trigger/destination register addresses, the transfer
//   length and the DMA state encodings.
// -----------------------------------------------------------------------------
package oam_dma_pkg;

  // Bus direction as seen on o_rw / i_cpu_rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Register addresses on the CPU bus
  localparam logic [15:0] DEF_DMA_TRIGGER_ADDRESS = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDRESS    = 16'h2004;

  // Bytes per transfer; the index counter is one bit wider than a page offset
  localparam int          DEF_TRANSFER_LENGTH     = 256;
  localparam int          IDX_W                   = 9;

  // DMA state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  // Source address for a given page and byte index. Only the low eight index
  // bits form the offset, so a transfer never carries into the page byte.
  function automatic logic [15:0] src_addr(input logic [7:0]       page,
                                           input logic [IDX_W-1:0] idx);
    return {page, idx[7:0]};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   Sprite DMA engine placed between the 6502 core and the system bus.
//   While idle the core's bus signals pass straight through. A core write to
//   the trigger address latches the written byte as a source page, stalls the
//   core through o_cpu_rdy and copies TRANSFER_LENGTH bytes from page $XX00
//   to the OAM data port, one read cycle followed by one write cycle per byte.
//   A dummy read (HALT), plus one more (ALIGN) when the bus parity is odd,
//   precedes the copy so reads always land on even cycles.
//
//   All state changes on the falling edge of i_clk, like the CPU core.
//
// Ports
//   i_clk           system clock (state on falling edge)
//   i_reset_n       asynchronous active-low reset
//   i_cpu_rw        core read/write, 1 = read, 0 = write
//   i_cpu_address   core address
//   i_cpu_data      core write data
//   o_cpu_rdy       1 = core may run, 0 = core must hold
//   o_rw            bus read/write
//   o_address       bus address
//   o_data          bus write data
//   i_data          bus read data (also feeds the core)
//   o_dma_active    1 whenever the engine is not idle
//   o_debug_state   current state encoding
//   o_debug_count   {7'b0, index}
// -----------------------------------------------------------------------------
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_TRIGGER_ADDRESS = DEF_DMA_TRIGGER_ADDRESS,
  parameter logic [15:0] OAM_DATA_ADDRESS    = DEF_OAM_DATA_ADDRESS,
  parameter int          TRANSFER_LENGTH     = DEF_TRANSFER_LENGTH
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_rdy,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        o_dma_active,
  output logic [7:0]  o_debug_state,
  output logic [15:0] o_debug_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANSFER_LENGTH - 1);

  logic [2:0]       state_q,  state_d;
  logic             rdy_q,    rdy_d;
  logic [IDX_W-1:0] index_q,  index_d;
  logic [7:0]       buffer_q, buffer_d;
  logic [7:0]       page_q,   page_d;
  logic             parity_q, parity_d;

  logic trigger;

  // Only a core write to the trigger address while idle starts a transfer;
  // the core is stalled otherwise and does not own the bus.
  assign trigger = (i_cpu_rw == RW_WRITE) && (i_cpu_address == DMA_TRIGGER_ADDRESS);

  // Free-running cycle parity, even = 0
  assign parity_d = ~parity_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    page_d   = page_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = i_cpu_data;
          state_d = ST_HALT;
          rdy_d   = 1'b0;
        end
      end
      ST_HALT: begin
        // Parity as it stands after this edge picks whether an extra
        // alignment cycle is needed before the first read.
        state_d = (parity_d == 1'b0) ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        buffer_d = i_data;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (index_q == LAST_IDX) begin
          index_d = '0;
          state_d = ST_IDLE;
          // Released on the edge leaving WRITE so the core's next cycle runs
          rdy_d   = 1'b1;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        index_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers, falling edge
  // ---------------------------------------------------------------------------
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b1;
      index_q  <= '0;
      buffer_q <= '0;
      page_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      page_q   <= page_d;
      parity_q <= parity_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus mux
  // ---------------------------------------------------------------------------
  always_comb begin
    o_rw      = RW_READ;
    o_address = i_cpu_address;
    o_data    = buffer_q;
    unique case (state_q)
      ST_IDLE: begin
        o_rw      = i_cpu_rw;
        o_address = i_cpu_address;
        o_data    = i_cpu_data;
      end
      ST_HALT, ST_ALIGN: begin
        // Dummy read of whatever the stalled core is presenting
        o_rw      = RW_READ;
        o_address = i_cpu_address;
      end
      ST_READ: begin
        o_rw      = RW_READ;
        o_address = src_addr(page_q, index_q);
      end
      ST_WRITE: begin
        o_rw      = RW_WRITE;
        o_address = OAM_DATA_ADDRESS;
      end
      default: begin
        o_rw      = i_cpu_rw;
        o_address = i_cpu_address;
        o_data    = i_cpu_data;
      end
    endcase
  end

  assign o_cpu_rdy     = rdy_q;
  assign o_dma_active  = (state_q != ST_IDLE);
  assign o_debug_state = {5'b0, state_q};
  assign o_debug_count = {7'b0, index_q};

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Randomized bench for the sprite DMA engine. A behavioural model builds the
//   full list of expected bus cycles for each transfer (dummy read(s), then
//   read/write pairs) from the cycle parity and page, and the bench compares
//   every stalled cycle against it. Bus RAM returns byte (addr[7:0] ^ $A5).
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cpu_rw;
  logic [15:0] i_cpu_address;
  logic [7:0]  i_cpu_data;
  logic        o_cpu_rdy;
  logic        o_rw;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic [7:0]  i_data;
  logic        o_dma_active;
  logic [7:0]  o_debug_state;
  logic [15:0] o_debug_count;

  oam_dma dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_cpu_rw      (i_cpu_rw),
    .i_cpu_address (i_cpu_address),
    .i_cpu_data    (i_cpu_data),
    .o_cpu_rdy     (o_cpu_rdy),
    .o_rw          (o_rw),
    .o_address     (o_address),
    .o_data        (o_data),
    .i_data        (i_data),
    .o_dma_active  (o_dma_active),
    .o_debug_state (o_debug_state),
    .o_debug_count (o_debug_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] ram(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  assign i_data = ram(o_address);

  // Falling edges seen since reset was released
  int unsigned nedge;
  always @(negedge i_clk or negedge i_reset_n)
    if (!i_reset_n) nedge <= 0;
    else            nedge <= nedge + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic [7:0]  st;
    logic [15:0] idx;
  } cyc_t;

  // Check combinational pass-through and idle flags against current inputs
  task automatic chk_pass(input string tag);
    chk({tag, "_rdy"},    32'(o_cpu_rdy),    32'd1);
    chk({tag, "_active"}, 32'(o_dma_active), 32'd0);
    chk({tag, "_rw"},     32'(o_rw),         32'(i_cpu_rw));
    chk({tag, "_addr"},   32'(o_address),    32'(i_cpu_address));
    if (i_cpu_rw == 1'b0) chk({tag, "_data"}, 32'(o_data), 32'(i_cpu_data));
  endtask

  // Random core traffic that never writes the trigger address
  task automatic idle_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      i_cpu_rw      = 1'($urandom);
      i_cpu_address = 16'($urandom);
      i_cpu_data    = 8'($urandom);
      if (!i_cpu_rw && i_cpu_address == 16'h4014) i_cpu_address = 16'h4016;
      #1 chk_pass("idle");
      @(posedge i_clk); #1;
    end
  endtask

  // One transfer. abort_n >= 0 asserts reset during the WRITE of that index.
  task automatic dma_run(input logic [7:0] page, input bit want_align, input int abort_n);
    cyc_t        exp_q[$];
    cyc_t        e;
    logic [15:0] hold;
    bit          align, done;
    int          ndum, k;

    while (nedge[0] != want_align) begin @(posedge i_clk); #1; end
    // Trigger edge is edge nedge+1, HALT leaves on nedge+2; odd parity then
    // costs one extra ALIGN cycle.
    align = ((nedge + 2) % 2) == 1;
    ndum  = align ? 2 : 1;
    hold  = 16'($urandom_range(0, 16'h3FFF));

    for (int d = 0; d < ndum; d++) begin
      e.rw = 1'b1; e.addr = hold; e.data = 8'h00; e.wr = 1'b0;
      e.st = 8'(d + 1); e.idx = 16'h0;
      exp_q.push_back(e);
    end
    for (int n = 0; n < 256; n++) begin
      e.rw = 1'b1; e.addr = {page, 8'(n)}; e.data = 8'h00; e.wr = 1'b0;
      e.st = 8'd3; e.idx = 16'(n);
      exp_q.push_back(e);
      e.rw = 1'b0; e.addr = 16'h2004; e.data = ram({page, 8'(n)}); e.wr = 1'b1;
      e.st = 8'd4; e.idx = 16'(n);
      exp_q.push_back(e);
    end

    // The trigger write itself goes out on the bus normally
    i_cpu_rw = 1'b0; i_cpu_address = 16'h4014; i_cpu_data = page;
    #1 chk_pass("trig");
    @(negedge i_clk); #1;
    i_cpu_rw = 1'b1; i_cpu_address = hold; i_cpu_data = 8'($urandom);

    k = 0; done = 1'b0;
    while (!done && k < 600) begin
      @(posedge i_clk);
      if (o_cpu_rdy) done = 1'b1;
      else begin
        if (k < exp_q.size()) begin
          e = exp_q[k];
          chk($sformatf("c%0d_active", k), 32'(o_dma_active),  32'd1);
          chk($sformatf("c%0d_rw", k),     32'(o_rw),          32'(e.rw));
          chk($sformatf("c%0d_addr", k),   32'(o_address),     32'(e.addr));
          chk($sformatf("c%0d_state", k),  32'(o_debug_state), 32'(e.st));
          chk($sformatf("c%0d_count", k),  32'(o_debug_count), 32'(e.idx));
          if (e.wr) chk($sformatf("c%0d_data", k), 32'(o_data), 32'(e.data));
        end
        if (abort_n >= 0 && k == ndum + 2 * abort_n + 1) begin
          i_reset_n = 1'b0;
          #1;
          chk("abort_rdy",    32'(o_cpu_rdy),     32'd1);
          chk("abort_active", 32'(o_dma_active),  32'd0);
          chk("abort_addr",   32'(o_address),     32'(hold));
          chk("abort_rw",     32'(o_rw),          32'd1);
          chk("abort_count",  32'(o_debug_count), 32'd0);
          @(posedge i_clk); #1;
          i_reset_n = 1'b1;
          return;
        end
        k++;
        #1;
        // A stray trigger while busy must be ignored
        if (k == ndum + 10) begin
          i_cpu_rw = 1'b0; i_cpu_address = 16'h4014; i_cpu_data = 8'h33;
        end
        if (k == ndum + 20) begin
          i_cpu_rw = 1'b1; i_cpu_address = hold;
        end
      end
    end

    chk($sformatf("stall_len_p%0h", page), 32'(k), 32'(exp_q.size()));
    chk("post_rdy",    32'(o_cpu_rdy),     32'd1);
    chk("post_active", 32'(o_dma_active),  32'd0);
    chk("post_addr",   32'(o_address),     32'(hold));
    chk("post_rw",     32'(o_rw),          32'd1);
    chk("post_count",  32'(o_debug_count), 32'd0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_cpu_rw = 1'b1; i_cpu_address = 16'h1234; i_cpu_data = 8'h00;
    #12;
    chk("rst_rdy",    32'(o_cpu_rdy),     32'd1);
    chk("rst_active", 32'(o_dma_active),  32'd0);
    chk("rst_state",  32'(o_debug_state), 32'd0);
    chk("rst_count",  32'(o_debug_count), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    #1 chk_pass("rst1234");
    chk("rst_addr1234", 32'(o_address), 32'h1234);

    idle_traffic(20);
    dma_run(8'h02, 1'b0, -1);   // even: 513 stall cycles
    idle_traffic(5);
    dma_run(8'h02, 1'b1, -1);   // odd: one ALIGN, 514 stall cycles

    // Near misses must not start a transfer
    i_cpu_rw = 1'b0; i_cpu_address = 16'h4015; i_cpu_data = 8'h02;
    #1 chk_pass("w4015");
    @(posedge i_clk); #1;
    i_cpu_rw = 1'b1; i_cpu_address = 16'h4014;
    #1 chk_pass("r4014");
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      chk_pass("nodma");
    end

    dma_run(8'hFF, 1'($urandom), -1);
    idle_traffic(3);
    dma_run(8'($urandom), 1'($urandom), 100);
    idle_traffic(3);
    dma_run(8'($urandom), 1'($urandom), -1);
    for (int r = 0; r < 2; r++) begin
      idle_traffic(int'($urandom_range(1, 8)));
      dma_run(8'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
